// File: rtl/fpu_issue.sv
// FPU issue stage: decodes MIPS COP1 instructions and holds them
// in an output register, stalling on RAW/WAW hazards via a scoreboard.
package fpu_pkg;
    typedef enum logic [3:0] {
        FPU_OP_INVALID,
        FPU_OP_LW,
        FPU_OP_SW,
        FPU_OP_MFC,
        FPU_OP_CFC,
        FPU_OP_MTC,
        FPU_OP_CTC,
        FPU_OP_ADD,
        FPU_OP_SUB,
        FPU_OP_MUL
    } FPUOper_t;

    typedef logic [31:0] Inst_t;
endpackage

module fpu_issue
    import fpu_pkg::*;
#(
    parameter int FPR_NUM      = 32,
    parameter int LAT_MEM      = 2,
    parameter int LAT_ARITH    = 4,
    parameter int ENABLE_ARITH = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inst_valid,
    input  Inst_t      inst,
    output logic       inst_ready,
    input  logic       flush,
    output logic       issue_valid,
    input  logic       issue_ready,
    output FPUOper_t   issue_op,
    output logic [4:0] issue_raddr1,
    output logic [4:0] issue_raddr2,
    output logic       issue_we,
    output logic [4:0] issue_waddr
);
    localparam int LAT_MAX = (LAT_MEM > LAT_ARITH) ? LAT_MEM : LAT_ARITH;
    localparam int CW      = $clog2(LAT_MAX + 1);

    logic [CW-1:0] cnt [FPR_NUM];

    logic [5:0] opc;
    logic [4:0] rs, ft, fs, fd;
    logic [5:0] funct;

    FPUOper_t      d_op;
    logic [4:0]    d_r1, d_r2, d_wa;
    logic          d_u1, d_u2, d_we;
    logic [CW-1:0] d_lat;

    logic hazard;
    logic accept;

    assign opc   = inst[31:26];
    assign rs    = inst[25:21];
    assign ft    = inst[20:16];
    assign fs    = inst[15:11];
    assign fd    = inst[10:6];
    assign funct = inst[5:0];

    function automatic logic pending(input logic [4:0] a);
        return (int'(a) < FPR_NUM) && (cnt[a] != '0);
    endfunction

    // Decode the offered word into operation, operands and use flags
    always_comb begin
        d_op  = FPU_OP_INVALID;
        d_r1  = '0;
        d_r2  = '0;
        d_wa  = '0;
        d_u1  = 1'b0;
        d_u2  = 1'b0;
        d_we  = 1'b0;
        d_lat = CW'(LAT_MEM);
        case (opc)
            6'b110001: begin
                d_op = FPU_OP_LW;
                d_wa = ft;
                d_we = 1'b1;
            end
            6'b111001: begin
                d_op = FPU_OP_SW;
                d_r1 = ft;
                d_u1 = 1'b1;
            end
            6'b010001: begin
                case (rs)
                    5'b00000: begin
                        d_op = FPU_OP_MFC;
                        d_r2 = fs;
                        d_u2 = 1'b1;
                    end
                    5'b00010: begin
                        d_op = FPU_OP_CFC;
                        d_r2 = fs;
                        d_u2 = 1'b1;
                    end
                    5'b00100: begin
                        d_op = FPU_OP_MTC;
                        d_wa = fs;
                        d_we = 1'b1;
                    end
                    5'b00110: begin
                        d_op = FPU_OP_CTC;
                        d_wa = fs;
                        d_we = 1'b1;
                    end
                    5'b10000: begin
                        if (ENABLE_ARITH != 0 && funct <= 6'd2) begin
                            case (funct)
                                6'd0:    d_op = FPU_OP_ADD;
                                6'd1:    d_op = FPU_OP_SUB;
                                default: d_op = FPU_OP_MUL;
                            endcase
                            d_r1  = fs;
                            d_r2  = ft;
                            d_wa  = fd;
                            d_u1  = 1'b1;
                            d_u2  = 1'b1;
                            d_we  = 1'b1;
                            d_lat = CW'(LAT_ARITH);
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Stall when a used source or the destination is still in flight
    always_comb begin
        hazard = (d_u1 && pending(d_r1)) ||
                 (d_u2 && pending(d_r2)) ||
                 (d_we && pending(d_wa));
    end

    assign inst_ready = !rst && !flush && !hazard &&
                        (!issue_valid || issue_ready);
    assign accept     = inst_valid && inst_ready;

    // Scoreboard: load latency on accepted writer, otherwise count down
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FPR_NUM; i++) cnt[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < FPR_NUM; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < FPR_NUM; i++) begin
                if (accept && d_we && d_wa == 5'(i)) cnt[i] <= d_lat;
                else if (cnt[i] != '0) cnt[i] <= cnt[i] - CW'(1);
            end
        end
    end

    // Output register with valid/ready handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_valid  <= 1'b0;
            issue_op     <= FPU_OP_INVALID;
            issue_raddr1 <= '0;
            issue_raddr2 <= '0;
            issue_we     <= 1'b0;
            issue_waddr  <= '0;
        end else if (flush) begin
            issue_valid <= 1'b0;
        end else if (accept) begin
            issue_valid  <= 1'b1;
            issue_op     <= d_op;
            issue_raddr1 <= d_r1;
            issue_raddr2 <= d_r2;
            issue_we     <= d_we;
            issue_waddr  <= d_wa;
        end else if (issue_ready) begin
            issue_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fpu_issue.sv
// Bench for fpu_issue: driver pushes expected issues into a queue,
// a monitor pops and compares whenever the DUT output is consumed.
module tb_fpu_issue;
    import fpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       inst_valid;
    Inst_t      inst;
    logic       inst_ready;
    logic       flush;
    logic       issue_valid;
    logic       issue_ready;
    FPUOper_t   issue_op;
    logic [4:0] issue_raddr1, issue_raddr2, issue_waddr;
    logic       issue_we;

    logic       inst_valid0;
    Inst_t      inst0;
    logic       inst_ready0;
    logic       flush0;
    logic       issue_valid0;
    logic       issue_ready0;
    FPUOper_t   issue_op0;
    logic [4:0] issue_raddr1_0, issue_raddr2_0, issue_waddr0;
    logic       issue_we0;

    fpu_issue dut (
        .clk(clk), .rst(rst),
        .inst_valid(inst_valid), .inst(inst), .inst_ready(inst_ready),
        .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op),
        .issue_raddr1(issue_raddr1), .issue_raddr2(issue_raddr2),
        .issue_we(issue_we), .issue_waddr(issue_waddr)
    );

    fpu_issue #(.ENABLE_ARITH(0)) dut0 (
        .clk(clk), .rst(rst),
        .inst_valid(inst_valid0), .inst(inst0), .inst_ready(inst_ready0),
        .flush(flush0),
        .issue_valid(issue_valid0), .issue_ready(issue_ready0),
        .issue_op(issue_op0),
        .issue_raddr1(issue_raddr1_0), .issue_raddr2(issue_raddr2_0),
        .issue_we(issue_we0), .issue_waddr(issue_waddr0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        FPUOper_t   op;
        logic [4:0] r1;
        logic [4:0] r2;
        logic       we;
        logic [4:0] wa;
        int         acc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int cnt_sum();
        int s = 0;
        for (int i = 0; i < 32; i++) s += int'(dut.cnt[i]);
        return s;
    endfunction

    // Monitor: compare each consumed output against the scoreboard
    initial begin
        bit   seen;
        int   first;
        exp_t e;
        seen = 0;
        first = 0;
        forever begin
            @(negedge clk);
            if (!issue_valid) begin
                seen = 0;
            end else begin
                if (!seen) begin
                    seen = 1;
                    first = cyc;
                end
                if (issue_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_issue", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("issue_op", issue_op, e.op);
                        chk("issue_raddr1", issue_raddr1, e.r1);
                        chk("issue_raddr2", issue_raddr2, e.r2);
                        chk("issue_we", issue_we, e.we);
                        chk("issue_waddr", issue_waddr, e.wa);
                        chk("issue_latency", first, e.acc + 1);
                    end
                    seen = 0;
                end
            end
        end
    end

    task automatic issue_inst(input Inst_t w, input FPUOper_t op,
                              input logic [4:0] r1, input logic [4:0] r2,
                              input logic we, input logic [4:0] wa,
                              output int acc);
        exp_t e;
        inst = w;
        inst_valid = 1'b1;
        acc = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (inst_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            chk("accept_timeout", 0, 1);
        end else begin
            e.op = op;
            e.r1 = r1;
            e.r2 = r2;
            e.we = we;
            e.wa = wa;
            e.acc = acc;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        inst = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, a, b, c0, c1, c2, c3, c4, h, s, k, f, x, r;
        rst = 1'b1;
        flush = 1'b0;
        issue_ready = 1'b1;
        inst_valid = 1'b1;
        inst = 32'hC404_0000;
        inst_valid0 = 1'b0;
        inst0 = '0;
        flush0 = 1'b0;
        issue_ready0 = 1'b1;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_issue_op", issue_op, FPU_OP_INVALID);
        chk("rst_raddr1", issue_raddr1, 0);
        chk("rst_raddr2", issue_raddr2, 0);
        chk("rst_we", issue_we, 0);
        chk("rst_waddr", issue_waddr, 0);
        chk("rst_inst_ready", inst_ready, 0);
        chk("rst_cnt4", dut.cnt[4], 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        inst_valid = 1'b0;

        // LW then dependent ADD (RAW), then LW to ADD's dest (WAW)
        issue_inst(32'hC404_0000, FPU_OP_LW, 0, 0, 1, 4, t);
        chk("cnt4_loaded", dut.cnt[4], 2);
        issue_inst(32'h4606_2080, FPU_OP_ADD, 4, 6, 1, 2, a);
        chk("raw_stall", a - t, 3);
        issue_inst(32'hC402_0000, FPU_OP_LW, 0, 0, 1, 2, b);
        chk("waw_stall", b - a, 5);

        // back-to-back independent instructions
        repeat (6) @(posedge clk);
        #1;
        issue_inst(32'h4480_2800, FPU_OP_MTC, 0, 0, 1, 5, c0);
        issue_inst(32'h4400_3800, FPU_OP_MFC, 0, 7, 0, 0, c1);
        issue_inst(32'h4603_1041, FPU_OP_SUB, 2, 3, 1, 1, c2);
        issue_inst(32'h460B_5242, FPU_OP_MUL, 10, 11, 1, 9, c3);
        issue_inst(32'h0000_0000, FPU_OP_INVALID, 0, 0, 0, 0, c4);
        chk("b2b_mfc", c1 - c0, 1);
        chk("b2b_sub", c2 - c0, 2);
        chk("b2b_mul", c3 - c0, 3);
        chk("b2b_inv", c4 - c0, 4);

        // invalid and SW leave the scoreboard untouched
        repeat (6) @(posedge clk);
        #1;
        issue_inst(32'hE404_0000, FPU_OP_SW, 4, 0, 0, 0, x);
        issue_inst(32'h0000_0000, FPU_OP_INVALID, 0, 0, 0, 0, x);
        chk("no_cnt_change", cnt_sum(), 0);

        // output held while downstream stalls
        repeat (2) @(posedge clk);
        #1;
        issue_ready = 1'b0;
        issue_inst(32'hC401_0000, FPU_OP_LW, 0, 0, 1, 1, h);
        inst = 32'hE408_0000;
        inst_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_inst_ready", inst_ready, 0);
            chk("hold_valid", issue_valid, 1);
            chk("hold_op", issue_op, FPU_OP_LW);
            chk("hold_waddr", issue_waddr, 1);
        end
        @(posedge clk);
        #1;
        issue_ready = 1'b1;
        k = cyc;
        issue_inst(32'hE408_0000, FPU_OP_SW, 8, 0, 0, 0, s);
        chk("accept_on_ready", s, k);

        // flush one cycle after accepting a writer
        repeat (2) @(posedge clk);
        #1;
        issue_ready = 1'b0;
        issue_inst(32'hC404_0000, FPU_OP_LW, 0, 0, 1, 4, f);
        flush = 1'b1;
        inst = 32'hE408_0000;
        inst_valid = 1'b1;
        q.delete();
        @(negedge clk);
        chk("flush_no_accept", inst_ready, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        inst_valid = 1'b0;
        chk("flush_valid", issue_valid, 0);
        chk("flush_cnt4", dut.cnt[4], 0);
        issue_ready = 1'b1;
        k = cyc;
        issue_inst(32'hE404_0000, FPU_OP_SW, 4, 0, 0, 0, x);
        chk("post_flush_accept", x, k);

        // reset asserted mid-operation
        repeat (2) @(posedge clk);
        #1;
        issue_ready = 1'b0;
        issue_inst(32'hC403_0000, FPU_OP_LW, 0, 0, 1, 3, r);
        rst = 1'b1;
        #1;
        chk("midrst_valid", issue_valid, 0);
        chk("midrst_cnt3", dut.cnt[3], 0);
        chk("midrst_ready", inst_ready, 0);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue_ready = 1'b1;
        k = cyc;
        issue_inst(32'hE403_0000, FPU_OP_SW, 3, 0, 0, 0, x);
        chk("post_rst_accept", x, k);

        // arithmetic disabled: ADD encoding becomes invalid
        inst0 = 32'h4606_2080;
        inst_valid0 = 1'b1;
        @(negedge clk);
        chk("noarith_ready", inst_ready0, 1);
        @(posedge clk);
        #1;
        inst_valid0 = 1'b0;
        @(negedge clk);
        chk("noarith_valid", issue_valid0, 1);
        chk("noarith_op", issue_op0, FPU_OP_INVALID);
        chk("noarith_we", issue_we0, 0);
        chk("noarith_waddr", issue_waddr0, 0);
        chk("noarith_raddr1", issue_raddr1_0, 0);
        chk("noarith_cnt2", dut0.cnt[2], 0);

        // drain the scoreboard
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        chk("drain_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
